// File: rtl/cdp1802_cycle_sched_if.sv
// ---------------------------------------------------------------------------
// cdp1802_cycle_sched_if
//   Bundles the machine-cycle sequencer's bus and handshake signals.
//   master : the sequencer (drives timing pulses, strobes, state code, steps)
//   slave  : core / system side (drives WAIT_N, DMA/INT requests, core status)
//
//   Inputs to the sequencer:
//     WAIT_N, DMA_IN_N, DMA_OUT_N, INT_N  - pause and level requests (active-low)
//     core_more, core_rd, core_wr         - core cycle needs
//     core_idle                           - core executing IDL
//     ie_set, ie_clr                      - interrupt-enable control pulses
//   Outputs from the sequencer:
//     SC, cpu_step, dma_step, dma_dir, int_ack, ie, TPA, TPB, MRD_N, MWR_N
// ---------------------------------------------------------------------------
interface cdp1802_cycle_sched_if;
    logic       WAIT_N;
    logic       DMA_IN_N;
    logic       DMA_OUT_N;
    logic       INT_N;
    logic       core_more;
    logic       core_rd;
    logic       core_wr;
    logic       core_idle;
    logic       ie_set;
    logic       ie_clr;
    logic [1:0] SC;
    logic       cpu_step;
    logic       dma_step;
    logic       dma_dir;
    logic       int_ack;
    logic       ie;
    logic       TPA;
    logic       TPB;
    logic       MRD_N;
    logic       MWR_N;

    modport master (
        input  WAIT_N, DMA_IN_N, DMA_OUT_N, INT_N,
        input  core_more, core_rd, core_wr, core_idle, ie_set, ie_clr,
        output SC, cpu_step, dma_step, dma_dir, int_ack, ie,
        output TPA, TPB, MRD_N, MWR_N
    );

    modport slave (
        output WAIT_N, DMA_IN_N, DMA_OUT_N, INT_N,
        output core_more, core_rd, core_wr, core_idle, ie_set, ie_clr,
        input  SC, cpu_step, dma_step, dma_dir, int_ack, ie,
        input  TPA, TPB, MRD_N, MWR_N
    );
endinterface

// File: rtl/cdp1802_cycle_sched.sv
// ---------------------------------------------------------------------------
// cdp1802_cycle_sched
//   Machine-cycle sequencer for the cdp1802 core. Splits CLOCK into
//   CYCLE_CLKS-clock machine cycles, generates TPA/TPB and the memory
//   strobes, and picks the next cycle type (S0 fetch, S1 execute, S2 DMA,
//   S3 interrupt) at every cycle boundary. Owns the IE flag.
//
//   Ports:
//     CLOCK    - system clock
//     CLEAR_N  - asynchronous active-low reset
//     bus      - cdp1802_cycle_sched_if.master (requests, core status,
//                timing pulses, strobes, SC, step pulses, ie)
//
//   Optional feature: define CDP1802_IDLE_EN to let the sequencer hold the
//   core in S1 while core_idle is high (IDL) until a DMA or interrupt cycle.
//   Without it core_idle is ignored.
// ---------------------------------------------------------------------------
module cdp1802_cycle_sched #(
    parameter int CYCLE_CLKS = 8,
    parameter int TPA_PH     = 1,
    parameter int TPB_PH     = 6
) (
    input  logic                         CLOCK,
    input  logic                         CLEAR_N,
    cdp1802_cycle_sched_if.master        bus
);

    localparam int PW = $clog2(CYCLE_CLKS);
    localparam logic [PW-1:0] LAST_IDX = PW'(CYCLE_CLKS - 1);
    localparam logic [PW-1:0] TPA_IDX  = PW'(TPA_PH);
    localparam logic [PW-1:0] TPB_IDX  = PW'(TPB_PH);
    localparam logic [PW-1:0] WR0_IDX  = PW'(TPB_PH - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_DMA,
        ST_INT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          dmai_p_q, dmai_p_d;
    logic          dmao_p_q, dmao_p_d;
    logic          int_p_q, int_p_d;
    logic          dma_dir_q, dma_dir_d;
    logic          ie_q, ie_d;
    logic          idle_q, idle_d;

    logic run;
    logic at_last;
    logic at_tpb;
    logic dma_req;
    logic int_req;

    assign run     = bus.WAIT_N;
    assign at_last = (phase_q == LAST_IDX);
    assign at_tpb  = (phase_q == TPB_IDX);
    assign dma_req = dmai_p_q | dmao_p_q;
    assign int_req = int_p_q & ie_q;

`ifndef CDP1802_IDLE_EN
    logic unused_idle;
    assign unused_idle = bus.core_idle;
`endif

    // Next-state logic. Nothing moves while WAIT_N is low.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dmai_p_d  = dmai_p_q;
        dmao_p_d  = dmao_p_q;
        int_p_d   = int_p_q;
        dma_dir_d = dma_dir_q;
        ie_d      = ie_q;
        idle_d    = idle_q;
        if (run) begin
            phase_d = at_last ? '0 : phase_q + 1'b1;

            // Requests are only looked at during S1/S2 (INIT also shows SC=01
            // but is not an execute cycle).
            if (at_tpb && (state_q == ST_EXEC || state_q == ST_DMA)) begin
                dmai_p_d = ~bus.DMA_IN_N;
                dmao_p_d = ~bus.DMA_OUT_N;
                int_p_d  = ~bus.INT_N;
            end

            if (bus.ie_clr) begin
                ie_d = 1'b0;
            end else if (bus.ie_set) begin
                ie_d = 1'b1;
            end

            if (at_last) begin
                idle_d = 1'b0;
                unique case (state_q)
                    ST_INIT:  state_d = ST_FETCH;
                    ST_FETCH: state_d = ST_EXEC;
                    ST_EXEC: begin
                        if (bus.core_more) begin
                            state_d = ST_EXEC;
                        end else if (dma_req) begin
                            state_d   = ST_DMA;
                            dma_dir_d = dmai_p_q;
                        end else if (int_req) begin
                            state_d = ST_INT;
                            ie_d    = 1'b0;
`ifdef CDP1802_IDLE_EN
                        end else if (bus.core_idle) begin
                            state_d = ST_EXEC;
                            idle_d  = 1'b1;
`endif
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                    ST_DMA: begin
                        if (dma_req) begin
                            state_d   = ST_DMA;
                            dma_dir_d = dmai_p_q;
                        end else if (int_req) begin
                            state_d = ST_INT;
                            ie_d    = 1'b0;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                    ST_INT:   state_d = ST_FETCH;
                    default:  state_d = ST_FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_q   <= ST_INIT;
            phase_q   <= '0;
            dmai_p_q  <= 1'b0;
            dmao_p_q  <= 1'b0;
            int_p_q   <= 1'b0;
            dma_dir_q <= 1'b0;
            ie_q      <= 1'b1;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dmai_p_q  <= dmai_p_d;
            dmao_p_q  <= dmao_p_d;
            int_p_q   <= int_p_d;
            dma_dir_q <= dma_dir_d;
            ie_q      <= ie_d;
            idle_q    <= idle_d;
        end
    end

    // Output decode from the registered phase/state. Pulses are gated by
    // WAIT_N so a paused machine never commits; strobes simply hold.
    logic rd_cycle;
    logic wr_cycle;
    logic wr_window;

    assign wr_cycle  = (state_q == ST_EXEC && bus.core_wr) ||
                       (state_q == ST_DMA  && dma_dir_q);
    // Write wins over read when the core asserts both.
    assign rd_cycle  = (state_q == ST_FETCH) ||
                       (state_q == ST_EXEC && bus.core_rd && !bus.core_wr && !idle_q) ||
                       (state_q == ST_DMA  && !dma_dir_q);
    assign wr_window = (phase_q == WR0_IDX) || (phase_q == TPB_IDX);

    always_comb begin
        unique case (state_q)
            ST_FETCH: bus.SC = 2'b00;
            ST_DMA:   bus.SC = 2'b10;
            ST_INT:   bus.SC = 2'b11;
            default:  bus.SC = 2'b01;
        endcase
    end

    assign bus.TPA      = run && (phase_q == TPA_IDX);
    assign bus.TPB      = run && at_tpb;
    assign bus.cpu_step = run && at_last &&
                          ((state_q == ST_FETCH) || (state_q == ST_EXEC && !idle_q));
    assign bus.dma_step = run && at_last && (state_q == ST_DMA);
    assign bus.int_ack  = run && at_last && (state_q == ST_INT);
    assign bus.dma_dir  = dma_dir_q;
    assign bus.ie       = ie_q;
    assign bus.MRD_N    = ~rd_cycle;
    assign bus.MWR_N    = ~(wr_cycle && wr_window);

endmodule

// File: tb/tb_cdp1802_cycle_sched.sv
module tb_cdp1802_cycle_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cdp1802_cycle_sched_if bus_if();

    cdp1802_cycle_sched #(
        .CYCLE_CLKS (8),
        .TPA_PH     (1),
        .TPB_PH     (6)
    ) dut (
        .CLOCK   (clk),
        .CLEAR_N (rst_n),
        .bus     (bus_if)
    );

    typedef struct {
        int         cyc;
        logic       rd;
        logic       wr;
        logic [1:0] sc;
        logic       tpa;
        logic       tpb;
        logic       cpu;
        logic       mrd;
        logic       mwr;
    } vec_t;

    vec_t vecs[15];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Advance on falling edges until the bench cycle counter reaches target.
    task automatic go(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        //           cyc rd    wr    sc     tpa   tpb   cpu   mrd   mwr
        vecs[0]  = '{0,  1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1,  1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{6,  1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{7,  1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{8,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{9,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{14, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{15, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{17, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{20, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{21, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{22, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{23, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{24, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n            = 1'b0;
        bus_if.WAIT_N    = 1'b1;
        bus_if.DMA_IN_N  = 1'b1;
        bus_if.DMA_OUT_N = 1'b1;
        bus_if.INT_N     = 1'b1;
        bus_if.core_more = 1'b0;
        bus_if.core_rd   = 1'b0;
        bus_if.core_wr   = 1'b0;
        bus_if.core_idle = 1'b0;
        bus_if.ie_set    = 1'b0;
        bus_if.ie_clr    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sc", 32'(bus_if.SC), 32'd1);
        chk("rst_ie", 32'(bus_if.ie), 32'd1);
        chk("rst_mrd", 32'(bus_if.MRD_N), 32'd1);
        chk("rst_mwr", 32'(bus_if.MWR_N), 32'd1);
        chk("rst_cpu_step", 32'(bus_if.cpu_step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Reset release: INIT, S0, S1 timing and strobes.
        for (int i = 0; i < 15; i++) begin
            go(vecs[i].cyc);
            bus_if.core_rd = vecs[i].rd;
            bus_if.core_wr = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_sc", i),  32'(bus_if.SC),       32'(vecs[i].sc));
            chk($sformatf("vec%0d_tpa", i), 32'(bus_if.TPA),      32'(vecs[i].tpa));
            chk($sformatf("vec%0d_tpb", i), 32'(bus_if.TPB),      32'(vecs[i].tpb));
            chk($sformatf("vec%0d_cpu", i), 32'(bus_if.cpu_step), 32'(vecs[i].cpu));
            chk($sformatf("vec%0d_mrd", i), 32'(bus_if.MRD_N),    32'(vecs[i].mrd));
            chk($sformatf("vec%0d_mwr", i), 32'(bus_if.MWR_N),    32'(vecs[i].mwr));
        end
        chk("init_ie", 32'(bus_if.ie), 32'd1);

        // DMA-in held through three samples -> three S2 cycles.
        go(33); bus_if.DMA_IN_N = 1'b0;
        go(39); #1; chk("a_s1_step", 32'(bus_if.cpu_step), 32'd1);
        go(40); #1;
        chk("a_sc_s2", 32'(bus_if.SC), 32'd2);
        chk("a_dir_in", 32'(bus_if.dma_dir), 32'd1);
        chk("a_mrd_hi", 32'(bus_if.MRD_N), 32'd1);
        go(44); #1; chk("a_mwr_ph4", 32'(bus_if.MWR_N), 32'd1);
        go(45); #1; chk("a_mwr_ph5", 32'(bus_if.MWR_N), 32'd0);
        go(46); #1; chk("a_mwr_ph6", 32'(bus_if.MWR_N), 32'd0);
        go(47); #1;
        chk("a_dma_step", 32'(bus_if.dma_step), 32'd1);
        chk("a_no_cpu_step", 32'(bus_if.cpu_step), 32'd0);
        go(48); #1; chk("a_sc_s2_2", 32'(bus_if.SC), 32'd2);
        go(55); bus_if.DMA_IN_N = 1'b1;
        go(56); #1; chk("a_sc_s2_3", 32'(bus_if.SC), 32'd2);
        go(64); #1; chk("a_sc_s0", 32'(bus_if.SC), 32'd0);

        // DMA-in and DMA-out together, then DMA-in released.
        go(73); bus_if.DMA_IN_N = 1'b0; bus_if.DMA_OUT_N = 1'b0;
        go(80); #1;
        chk("b_sc_s2", 32'(bus_if.SC), 32'd2);
        chk("b_dir_in", 32'(bus_if.dma_dir), 32'd1);
        go(81); bus_if.DMA_IN_N = 1'b1;
        go(82); #1;
        chk("b_dir_in_hold", 32'(bus_if.dma_dir), 32'd1);
        chk("b_mrd_hi", 32'(bus_if.MRD_N), 32'd1);
        go(88); #1;
        chk("b_sc_s2_out", 32'(bus_if.SC), 32'd2);
        chk("b_dir_out", 32'(bus_if.dma_dir), 32'd0);
        chk("b_mrd_lo", 32'(bus_if.MRD_N), 32'd0);
        go(89); bus_if.DMA_OUT_N = 1'b1;
        go(93); #1;
        chk("b_mrd_lo_ph5", 32'(bus_if.MRD_N), 32'd0);
        chk("b_mwr_hi_ph5", 32'(bus_if.MWR_N), 32'd1);
        go(96); #1; chk("b_sc_s0", 32'(bus_if.SC), 32'd0);

        // Interrupt with ie=1, then held request blocked until ie_set.
        go(105); bus_if.INT_N = 1'b0;
        go(111); #1;
        chk("c_ie_before", 32'(bus_if.ie), 32'd1);
        chk("c_sc_s1", 32'(bus_if.SC), 32'd1);
        go(112); #1;
        chk("c_sc_s3", 32'(bus_if.SC), 32'd3);
        chk("c_ie_clr", 32'(bus_if.ie), 32'd0);
        go(119); #1;
        chk("c_int_ack", 32'(bus_if.int_ack), 32'd1);
        chk("c_no_cpu", 32'(bus_if.cpu_step), 32'd0);
        chk("c_no_dma", 32'(bus_if.dma_step), 32'd0);
        go(120); #1; chk("c_sc_s0", 32'(bus_if.SC), 32'd0);
        go(135); #1; chk("c_no_ack", 32'(bus_if.int_ack), 32'd0);
        go(136); #1; chk("c_no_second_s3", 32'(bus_if.SC), 32'd0);
        go(140); bus_if.ie_set = 1'b1;
        go(141); bus_if.ie_set = 1'b0; #1;
        chk("c_ie_set", 32'(bus_if.ie), 32'd1);
        go(152); #1;
        chk("c_sc_s3_again", 32'(bus_if.SC), 32'd3);
        chk("c_ie_clr2", 32'(bus_if.ie), 32'd0);
        go(153); bus_if.INT_N = 1'b1;
        go(159); #1; chk("c_int_ack2", 32'(bus_if.int_ack), 32'd1);
        go(170); bus_if.ie_set = 1'b1;
        go(171); bus_if.ie_set = 1'b0; #1;
        chk("c_ie_set2", 32'(bus_if.ie), 32'd1);
        go(172); bus_if.ie_set = 1'b1; bus_if.ie_clr = 1'b1;
        go(173); bus_if.ie_set = 1'b0; bus_if.ie_clr = 1'b0; #1;
        chk("c_ie_clr_wins", 32'(bus_if.ie), 32'd0);
        go(174); bus_if.ie_set = 1'b1;
        go(175); bus_if.ie_set = 1'b0; #1;
        chk("c_ie_set3", 32'(bus_if.ie), 32'd1);
        go(176); #1; chk("c_sc_s0_end", 32'(bus_if.SC), 32'd0);

        // DMA-out beats interrupt at the same sample.
        go(185); bus_if.DMA_OUT_N = 1'b0; bus_if.INT_N = 1'b0;
        go(192); #1;
        chk("d_sc_s2", 32'(bus_if.SC), 32'd2);
        chk("d_dir_out", 32'(bus_if.dma_dir), 32'd0);
        chk("d_mrd_lo", 32'(bus_if.MRD_N), 32'd0);
        go(193); bus_if.DMA_OUT_N = 1'b1;
        go(199); #1; chk("d_dma_step", 32'(bus_if.dma_step), 32'd1);
        go(200); #1;
        chk("d_sc_s3", 32'(bus_if.SC), 32'd3);
        chk("d_ie_clr", 32'(bus_if.ie), 32'd0);
        go(201); bus_if.INT_N = 1'b1;
        go(208); #1; chk("d_sc_s0", 32'(bus_if.SC), 32'd0);

        // WAIT_N low for 20 clocks at phase 3 of an S0 cycle.
        go(227); bus_if.WAIT_N = 1'b0; #1;
        chk("e_sc_frozen", 32'(bus_if.SC), 32'd0);
        chk("e_mrd_frozen", 32'(bus_if.MRD_N), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("e_sc_frozen2", 32'(bus_if.SC), 32'd0);
        chk("e_mrd_frozen2", 32'(bus_if.MRD_N), 32'd0);
        bus_if.WAIT_N = 1'b1;
        go(229); #1; chk("e_no_tpb_ph5", 32'(bus_if.TPB), 32'd0);
        go(230); #1; chk("e_tpb_resume", 32'(bus_if.TPB), 32'd1);
        go(231); bus_if.WAIT_N = 1'b0; #1;
        chk("e_step_gated", 32'(bus_if.cpu_step), 32'd0);
        bus_if.WAIT_N = 1'b1; #1;
        chk("e_step_ungated", 32'(bus_if.cpu_step), 32'd1);
        go(232); #1; chk("e_sc_s1", 32'(bus_if.SC), 32'd1);

        // Reset in the middle of a DMA-in S2 write strobe.
        go(233); bus_if.DMA_IN_N = 1'b0;
        go(240); #1; chk("f_sc_s2", 32'(bus_if.SC), 32'd2);
        go(245); #1; chk("f_mwr_lo", 32'(bus_if.MWR_N), 32'd0);
        rst_n = 1'b0;
        bus_if.DMA_IN_N = 1'b1;
        #1;
        chk("f_rst_sc", 32'(bus_if.SC), 32'd1);
        chk("f_rst_mwr", 32'(bus_if.MWR_N), 32'd1);
        chk("f_rst_mrd", 32'(bus_if.MRD_N), 32'd1);
        chk("f_rst_ie", 32'(bus_if.ie), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1; chk("f_init_sc", 32'(bus_if.SC), 32'd1);
        go(7); #1; chk("f_init_no_step", 32'(bus_if.cpu_step), 32'd0);
        go(8); #1; chk("f_fetch", 32'(bus_if.SC), 32'd0);

        // core_more keeps the sequencer in S1 for another cycle.
        go(16); bus_if.core_more = 1'b1;
        go(23); #1; chk("g_s1_step", 32'(bus_if.cpu_step), 32'd1);
        go(24); bus_if.core_more = 1'b0; #1;
        chk("g_sc_s1_again", 32'(bus_if.SC), 32'd1);
        go(32); #1; chk("g_sc_s0", 32'(bus_if.SC), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdp1802_cycle_sched.md
Name: cdp1802_cycle_sched

Overview:
- Machine-cycle sequencer for the cdp1802 core. Divides CLOCK into 8-clock machine cycles and emits TPA/TPB, MRD_N/MWR_N and the state code SC.
- At each cycle boundary, decides whether the next cycle is fetch (S0), execute (S1), DMA (S2) or interrupt (S3).
- Arbitrates the core's RAM port between instruction execution and DMA-in/DMA-out requests (video, cassette).
- Owns the interrupt-enable (IE) flag.

Parameters:
- CYCLE_CLKS, 8, clocks per machine cycle; legal range 4..16.
- TPA_PH, 1, phase index at which TPA is high for one clock.
- TPB_PH, 6, phase index at which TPB is high for one clock; must satisfy TPA_PH < TPB_PH < CYCLE_CLKS-1.

Ports:
- CLOCK  in  1  system clock.
- CLEAR_N  in  1  reset, asynchronous, active-low.
- WAIT_N  in  1  low (with CLEAR_N high) = pause: phase counter and all state frozen.
- DMA_IN_N  in  1  DMA-in request, active-low, level.
- DMA_OUT_N  in  1  DMA-out request, active-low, level.
- INT_N  in  1  interrupt request, active-low, level.
- core_more  in  1  core needs a further S1 cycle (long branch/skip, two-cycle ops); valid at phase CYCLE_CLKS-1.
- core_rd  in  1  core's current cycle reads memory.
- core_wr  in  1  core's current cycle writes memory.
- core_idle  in  1  core is executing IDL (opcode 00); used only with the optional feature.
- ie_set  in  1  one-clock pulse from core (RET): IE <= 1.
- ie_clr  in  1  one-clock pulse from core (DIS): IE <= 0.
- SC  out  2  state code: 00 S0, 01 S1, 10 S2, 11 S3.
- cpu_step  out  1  one-clock pulse at last phase of an S0/S1 cycle; core commits.
- dma_step  out  1  one-clock pulse at last phase of an S2 cycle; core commits R0 increment.
- dma_dir  out  1  direction of the current S2 cycle: 1 = DMA-in (memory write), 0 = DMA-out (memory read).
- int_ack  out  1  one-clock pulse at last phase of an S3 cycle; core saves X,P into T and sets X=2, P=1.
- ie  out  1  interrupt-enable flag.
- TPA  out  1  timing pulse A.
- TPB  out  1  timing pulse B.
- MRD_N  out  1  memory read strobe, active-low.
- MWR_N  out  1  memory write strobe, active-low.

Behaviour:
- Reset (CLEAR_N low, asynchronous): phase=0, state=INIT, SC=01, ie=1, all pulses 0, MRD_N=MWR_N=1, latched requests cleared.
- Phase counter: 0..CYCLE_CLKS-1, wraps; advances only when WAIT_N=1. With WAIT_N=0 every register holds and pulse outputs are forced 0.
- TPA=1 when phase==TPA_PH. TPB=1 when phase==TPB_PH.
- MRD_N: low for the whole cycle when the cycle reads: S0; S1 with core_rd; S2 with dma_dir=0.
- MWR_N: low at phases TPB_PH-1..TPB_PH when the cycle writes: S1 with core_wr; S2 with dma_dir=1.
- core_rd and core_wr both high: write wins, MRD_N=1.
- Request sampling: DMA_IN_N, DMA_OUT_N and INT_N are registered at the TPB clock of every S1 and S2 cycle into dmai_p, dmao_p, int_p. Requests are not sampled in S0, S3 or INIT.
- States, evaluated at phase CYCLE_CLKS-1:
  - INIT (SC=01, one cycle, no strobes) -> FETCH.
  - FETCH -> EXEC.
  - EXEC: core_more -> EXEC. Else dmai_p|dmao_p -> DMA. Else int_p&ie -> INT. Else FETCH.
  - DMA: dmai_p|dmao_p -> DMA. Else int_p&ie -> INT. Else FETCH.
  - INT -> FETCH.
- DMA priority: DMA-in over DMA-out. dma_dir is latched on entry to each S2 cycle.
- Interrupt priority: DMA beats interrupt in the same boundary.
- IE update: ie cleared on the INT entry clock. ie_set/ie_clr are applied on any clock; if both are high, ie_clr wins. INT entry overrides ie_set in the same clock.
- Pulse timing: cpu_step, dma_step and int_ack are high exactly on the phase CYCLE_CLKS-1 clock of their cycle type, and never overlap.
- Reset mid-cycle: all outputs return to reset values immediately. The first cycle after release is INIT.

Optional Feature:
- Macro: CDP1802_IDLE_EN.
- Defined: in EXEC with core_idle=1 and no pending DMA or enabled interrupt, the next state is EXEC; the core holds. MRD_N stays high during idle S1 cycles. cpu_step is suppressed until the idle is exited via DMA or INT. After the DMA/INT cycle the sequence goes to FETCH.
- Undefined: core_idle is ignored. The core must implement IDL itself via core_more.

Test Plan:
- Reset release, CYCLE_CLKS=8: SC=01 for 8 clocks (INIT), then S0/S1 alternating. TPA at phases 1 and 9, TPB at 6 and 14. cpu_step on clocks 15, 23, ...; ie=1.
- DMA_IN_N low before TPB of an S1 with core_more=0: next SC=10, dma_dir=1, MWR_N low at phases 5-6. Request held 3 S1/S2 cycles -> 3 S2 cycles, then S0.
- DMA_IN_N and DMA_OUT_N both low, then DMA_IN_N high: S2 cycles with dma_dir=1 until the next TPB sample, then dma_dir=0 with MRD_N low for the whole cycle.
- INT_N low with ie=1: S1 -> S3 -> S0; int_ack pulses once; ie=0. Hold INT_N low: no second S3 until ie_set pulses.
- INT_N and DMA_OUT_N both low at the same TPB: S2 first, then S3 after DMA_OUT_N deasserts.
- WAIT_N low for 20 clocks mid-cycle at phase 3: phase, SC and strobes frozen; resumes at phase 3. CLEAR_N low mid-S2: SC=01 and MWR_N=1 immediately.
